// File: rtl/ram_16x8_responder_pkg.sv
// ----------------------------------------------------------------------------
// ram_16x8_responder_pkg
//   Shared defaults for the 16x8 main memory and the loader state encoding.
//   DEF_ADDR_BITS / DEF_DATA_BITS : default address and word widths
//   ld_state_e                    : loader FSM states (2-bit)
// ----------------------------------------------------------------------------
package ram_16x8_responder_pkg;

  localparam int DEF_ADDR_BITS = 4;
  localparam int DEF_DATA_BITS = 8;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/ram_16x8_responder_if.sv
// ----------------------------------------------------------------------------
// ram_16x8_responder_if
//   Bus bundle for the main memory: run-mode port (address, data_in, ram_in,
//   ram_out, data_out, out_valid) and loader port (prog_mode, prog_start_addr,
//   prog_data, prog_valid, prog_ready, prog_addr, prog_done).
//   slave  : memory side
//   master : CPU / loader source side
// ----------------------------------------------------------------------------
interface ram_16x8_responder_if
  import ram_16x8_responder_pkg::*;
#(
  parameter int RAM_ADDRESS_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS        = DEF_DATA_BITS
) ();

  logic [RAM_ADDRESS_BITS-1:0] address;
  logic [DATA_BITS-1:0]        data_in;
  logic                        ram_in;
  logic                        ram_out;
  logic [DATA_BITS-1:0]        data_out;
  logic                        out_valid;
  logic                        prog_mode;
  logic [RAM_ADDRESS_BITS-1:0] prog_start_addr;
  logic [DATA_BITS-1:0]        prog_data;
  logic                        prog_valid;
  logic                        prog_ready;
  logic [RAM_ADDRESS_BITS-1:0] prog_addr;
  logic                        prog_done;

  modport slave (
    input  address, data_in, ram_in, ram_out,
    input  prog_mode, prog_start_addr, prog_data, prog_valid,
    output data_out, out_valid, prog_ready, prog_addr, prog_done
  );

  modport master (
    output address, data_in, ram_in, ram_out,
    output prog_mode, prog_start_addr, prog_data, prog_valid,
    input  data_out, out_valid, prog_ready, prog_addr, prog_done
  );

endinterface

// File: rtl/ram_16x8_responder_loader_fsm.sv
// ----------------------------------------------------------------------------
// ram_loader_fsm
//   Program-mode loader: fills memory from a valid/ready byte source,
//   auto-incrementing from a start address sampled on entry to LOAD.
//   clk, reset          : clock, async active-high reset
//   prog_mode_i         : 1 = program mode
//   prog_start_addr_i   : first address to fill
//   prog_data_i/valid_i : byte source
//   prog_ready_o        : byte accepted this cycle (with valid)
//   prog_addr_o         : next address to write
//   prog_done_o         : last address written
//   idle_o              : FSM in IDLE (run port may operate)
//   wr_en_o/addr_o/data_o : memory write request to the top
// ----------------------------------------------------------------------------
module ram_loader_fsm
  import ram_16x8_responder_pkg::*;
#(
  parameter int RAM_ADDRESS_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS        = DEF_DATA_BITS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        prog_mode_i,
  input  logic [RAM_ADDRESS_BITS-1:0] prog_start_addr_i,
  input  logic [DATA_BITS-1:0]        prog_data_i,
  input  logic                        prog_valid_i,
  output logic                        prog_ready_o,
  output logic [RAM_ADDRESS_BITS-1:0] prog_addr_o,
  output logic                        prog_done_o,
  output logic                        idle_o,
  output logic                        wr_en_o,
  output logic [RAM_ADDRESS_BITS-1:0] wr_addr_o,
  output logic [DATA_BITS-1:0]        wr_data_o
);

  localparam logic [RAM_ADDRESS_BITS-1:0] LAST_ADDR = '1;

  ld_state_e                   state_q;
  logic [RAM_ADDRESS_BITS-1:0] addr_q;
  logic                        done_q;
  logic                        accept;

  // Ready drops in the same cycle prog_mode drops, so an abort never writes.
  assign prog_ready_o = (state_q == LD_LOAD) & prog_mode_i;
  assign accept       = prog_ready_o & prog_valid_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LD_IDLE;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        LD_IDLE: begin
          if (prog_mode_i) begin
            state_q <= LD_LOAD;
            addr_q  <= prog_start_addr_i;
          end
        end
        LD_LOAD: begin
          if (!prog_mode_i) begin
            state_q <= LD_IDLE;
          end else if (accept) begin
            // Pointer wraps to 0 after the top word; the top word ends the load.
            addr_q <= addr_q + 1'b1;
            if (addr_q == LAST_ADDR) begin
              state_q <= LD_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        LD_DONE: begin
          if (!prog_mode_i) begin
            state_q <= LD_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= LD_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign prog_addr_o = addr_q;
  assign prog_done_o = done_q;
  assign idle_o      = (state_q == LD_IDLE);
  assign wr_en_o     = accept;
  assign wr_addr_o   = addr_q;
  assign wr_data_o   = prog_data_i;

endmodule

// File: rtl/ram_16x8_responder.sv
// ----------------------------------------------------------------------------
// ram_16x8_responder
//   Main memory of the 8-bit computer. Run mode writes/reads the word at the
//   MAR address; program mode hands the array to the loader FSM.
//   clk   : system clock
//   reset : async active-high; clears outputs and loader, not the array
//   bus   : ram_16x8_responder_if.slave (run port + loader port)
// ----------------------------------------------------------------------------
module ram_16x8_responder
  import ram_16x8_responder_pkg::*;
#(
  parameter int RAM_ADDRESS_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS        = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  ram_16x8_responder_if.slave  bus
);

  localparam int DEPTH = 1 << RAM_ADDRESS_BITS;

  logic [DATA_BITS-1:0]        mem_q [DEPTH];
  logic [DATA_BITS-1:0]        data_out_q, data_out_d;
  logic                        out_valid_q, out_valid_d;

  logic                        ld_idle;
  logic                        ld_we;
  logic [RAM_ADDRESS_BITS-1:0] ld_waddr;
  logic [DATA_BITS-1:0]        ld_wdata;
  logic                        run_en;
  logic                        rd_fire;

  ram_loader_fsm #(
    .RAM_ADDRESS_BITS (RAM_ADDRESS_BITS),
    .DATA_BITS        (DATA_BITS)
  ) u_loader (
    .clk               (clk),
    .reset             (reset),
    .prog_mode_i       (bus.prog_mode),
    .prog_start_addr_i (bus.prog_start_addr),
    .prog_data_i       (bus.prog_data),
    .prog_valid_i      (bus.prog_valid),
    .prog_ready_o      (bus.prog_ready),
    .prog_addr_o       (bus.prog_addr),
    .prog_done_o       (bus.prog_done),
    .idle_o            (ld_idle),
    .wr_en_o           (ld_we),
    .wr_addr_o         (ld_waddr),
    .wr_data_o         (ld_wdata)
  );

  // Run strobes only count in IDLE with prog_mode low; an IDLE cycle with
  // prog_mode high is the entry into LOAD and ignores them.
  assign run_en  = ld_idle & ~bus.prog_mode;
  assign rd_fire = run_en & bus.ram_out;

  // Array has no reset so a loaded program survives a CPU reset. Loader
  // writes and run writes are mutually exclusive by state.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem_q[ld_waddr] <= ld_wdata;
    end else if (run_en && bus.ram_in) begin
      mem_q[bus.address] <= bus.data_in;
    end
  end

  // Read samples the pre-edge array contents, giving read-before-write.
  always_comb begin
    data_out_d  = data_out_q;
    out_valid_d = rd_fire;
    if (rd_fire) data_out_d = mem_q[bus.address];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;

endmodule
